// File: rtl/ccu_snoop_resp_collector.sv
// Snoop response collector: snoops every master except the initiator, merges the
// CR responses and sequences the memory-unit operations that the merged result needs.
package ccu_ctrl_pkg;
  typedef enum logic [1:0] {
    SEND_AXI_REQ_R = 2'd0,
    SEND_AXI_REQ_W = 2'd1,
    WRITE_BACK_R   = 2'd2,
    WRITE_BACK_W   = 2'd3
  } mu_op_e;
endpackage

module ccu_snoop_resp_collector
  import ccu_ctrl_pkg::*;
#(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned AddrWidth  = 64,
  localparam int unsigned MstIdxBits = $clog2(NoMstPorts)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_is_write_i,
  input  logic [MstIdxBits-1:0]      req_src_i,
  input  logic [AddrWidth-1:0]       req_addr_i,
  output logic [NoMstPorts-1:0]      ac_valid_o,
  input  logic [NoMstPorts-1:0]      ac_ready_i,
  output logic [AddrWidth-1:0]       ac_addr_o,
  output logic [3:0]                 ac_snoop_o,
  input  logic [NoMstPorts-1:0]      cr_valid_i,
  output logic [NoMstPorts-1:0]      cr_ready_o,
  input  logic [NoMstPorts-1:0][4:0] cr_resp_i,
  input  logic                       cd_busy_i,
  output logic                       mu_valid_o,
  input  logic                       mu_ready_i,
  output mu_op_e                     mu_op_o,
  output logic [NoMstPorts-1:0]      data_available_o,
  output logic [MstIdxBits-1:0]      first_responder_o,
  output logic                       done_valid_o,
  input  logic                       done_ready_i,
  output logic                       shared_o,
  output logic                       dirty_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNOOP   = 3'd1,
    MU_REQ  = 3'd2,
    MU_REQ2 = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  mu_op_e                  mu_op_q, mu_op_d;
  logic                    is_write_q, is_write_d;
  logic [MstIdxBits-1:0]   src_q, src_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [NoMstPorts-1:0]   ac_done_q, ac_done_d;
  logic [NoMstPorts-1:0]   cr_done_q, cr_done_d;
  logic [NoMstPorts-1:0]   data_avail_q, data_avail_d;
  logic                    dirty_q, dirty_d;
  logic                    shared_q, shared_d;
  logic                    found_q, found_d;
  logic [MstIdxBits-1:0]   first_q, first_d;

  logic [NoMstPorts-1:0]   target_s;
  logic [NoMstPorts-1:0]   cr_data_s;
  logic [NoMstPorts-1:0]   ac_hs_s;
  logic [NoMstPorts-1:0]   cr_hs_s;
  logic [NoMstPorts-1:0]   pick_s;
  logic                    unused_was_unique_s;

  // Target mask and per-port "response carries usable data" decode.
  always_comb begin
    target_s            = {NoMstPorts{1'b0}};
    cr_data_s           = {NoMstPorts{1'b0}};
    unused_was_unique_s = 1'b0;
    for (int i = 0; i < NoMstPorts; i++) begin
      target_s[i]         = (src_q != MstIdxBits'(i));
      cr_data_s[i]        = cr_resp_i[i][0] & ~cr_resp_i[i][1];
      unused_was_unique_s = unused_was_unique_s ^ cr_resp_i[i][4];
    end
  end

  assign req_ready_o       = ~rst_i & (state_q == IDLE) & ~cd_busy_i;
  assign ac_valid_o        = (state_q == SNOOP) ? (target_s & ~ac_done_q) : {NoMstPorts{1'b0}};
  assign cr_ready_o        = (state_q == SNOOP) ? (target_s & ~cr_done_q) : {NoMstPorts{1'b0}};
  assign ac_hs_s           = ac_valid_o & ac_ready_i;
  assign cr_hs_s           = cr_valid_i & cr_ready_o;
  assign ac_addr_o         = addr_q & {{(AddrWidth-4){1'b1}}, 4'b0000};
  assign ac_snoop_o        = (state_q != SNOOP) ? 4'b0000 : (is_write_q ? 4'b1001 : 4'b0001);
  assign mu_valid_o        = (state_q == MU_REQ) | ((state_q == MU_REQ2) & ~cd_busy_i);
  assign done_valid_o      = (state_q == DONE);
  assign mu_op_o           = mu_op_q;
  assign data_available_o  = data_avail_q;
  assign first_responder_o = first_q;
  assign shared_o          = shared_q;
  assign dirty_o           = dirty_q;

  // First data responder: only the lowest-index data handshake of the earliest cycle wins.
  always_comb begin
    pick_s = {NoMstPorts{1'b0}};
    for (int i = 0; i < NoMstPorts; i++) begin
      pick_s[i] = cr_hs_s[i] & cr_data_s[i] & ~found_q & ~|(pick_s & ((NoMstPorts'(1) << i) - NoMstPorts'(1)));
    end
  end

  // Next-state and datapath updates for the collector FSM.
  always_comb begin
    state_d      = state_q;
    mu_op_d      = mu_op_q;
    is_write_d   = is_write_q;
    src_d        = src_q;
    addr_d       = addr_q;
    ac_done_d    = ac_done_q;
    cr_done_d    = cr_done_q;
    data_avail_d = data_avail_q;
    dirty_d      = dirty_q;
    shared_d     = shared_q;
    found_d      = found_q;
    first_d      = first_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          state_d      = SNOOP;
          is_write_d   = req_is_write_i;
          src_d        = req_src_i;
          addr_d       = req_addr_i;
          ac_done_d    = {NoMstPorts{1'b0}};
          cr_done_d    = {NoMstPorts{1'b0}};
          data_avail_d = {NoMstPorts{1'b0}};
          dirty_d      = 1'b0;
          shared_d     = 1'b0;
          found_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SNOOP: begin
        ac_done_d = ac_done_q | ac_hs_s;
        cr_done_d = cr_done_q | cr_hs_s;
        found_d   = found_q | (|pick_s);
        for (int i = 0; i < NoMstPorts; i++) begin
          data_avail_d[i] = cr_hs_s[i] ? cr_data_s[i] : data_avail_q[i];
          dirty_d         = dirty_d | (cr_hs_s[i] & cr_data_s[i] & cr_resp_i[i][2]);
          shared_d        = shared_d | (cr_hs_s[i] & cr_resp_i[i][3]);
          first_d         = pick_s[i] ? MstIdxBits'(i) : first_d;
        end
        // Decision uses the registered masks, so exit happens the cycle after the last handshake.
        if ((ac_done_q == target_s) && (cr_done_q == target_s)) begin
          if (is_write_q) begin
            state_d = MU_REQ;
            if (dirty_q) begin
              mu_op_d = WRITE_BACK_W;
            end else begin
              mu_op_d = SEND_AXI_REQ_W;
            end
          end else if (dirty_q) begin
            state_d = MU_REQ;
            mu_op_d = WRITE_BACK_R;
          end else if (data_avail_q == {NoMstPorts{1'b0}}) begin
            state_d = MU_REQ;
            mu_op_d = SEND_AXI_REQ_R;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = SNOOP;
        end
      end
      MU_REQ: begin
        if (mu_ready_i) begin
          if (is_write_q && dirty_q) begin
            state_d = MU_REQ2;
            mu_op_d = SEND_AXI_REQ_W;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = MU_REQ;
        end
      end
      MU_REQ2: begin
        if (mu_valid_o && mu_ready_i) begin
          state_d = DONE;
        end else begin
          state_d = MU_REQ2;
        end
      end
      DONE: begin
        if (done_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mu_op_q      <= SEND_AXI_REQ_R;
      is_write_q   <= 1'b0;
      src_q        <= {MstIdxBits{1'b0}};
      addr_q       <= {AddrWidth{1'b0}};
      ac_done_q    <= {NoMstPorts{1'b0}};
      cr_done_q    <= {NoMstPorts{1'b0}};
      data_avail_q <= {NoMstPorts{1'b0}};
      dirty_q      <= 1'b0;
      shared_q     <= 1'b0;
      found_q      <= 1'b0;
      first_q      <= {MstIdxBits{1'b0}};
    end else begin
      state_q      <= state_d;
      mu_op_q      <= mu_op_d;
      is_write_q   <= is_write_d;
      src_q        <= src_d;
      addr_q       <= addr_d;
      ac_done_q    <= ac_done_d;
      cr_done_q    <= cr_done_d;
      data_avail_q <= data_avail_d;
      dirty_q      <= dirty_d;
      shared_q     <= shared_d;
      found_q      <= found_d;
      first_q      <= first_d;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_resp_collector.sv
// Bench for ccu_snoop_resp_collector: transaction-level model feeds a scoreboard queue,
// a negedge monitor pops and compares on every MU and completion handshake.
module tb_ccu_snoop_resp_collector;
  import ccu_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic             req_is_write_i = 1'b0;
  logic [1:0]       req_src_i = 2'd0;
  logic [63:0]      req_addr_i = 64'd0;
  logic [3:0]       ac_valid_o;
  logic [3:0]       ac_ready_i = 4'd0;
  logic [63:0]      ac_addr_o;
  logic [3:0]       ac_snoop_o;
  logic [3:0]       cr_valid_i = 4'd0;
  logic [3:0]       cr_ready_o;
  logic [3:0][4:0]  cr_resp_i = '0;
  logic             cd_busy_i = 1'b0;
  logic             mu_valid_o;
  logic             mu_ready_i = 1'b0;
  mu_op_e           mu_op_o;
  logic [3:0]       data_available_o;
  logic [1:0]       first_responder_o;
  logic             done_valid_o;
  logic             done_ready_i = 1'b0;
  logic             shared_o;
  logic             dirty_o;

  always #5 clk = ~clk;

  ccu_snoop_resp_collector dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_is_write_i   (req_is_write_i),
    .req_src_i        (req_src_i),
    .req_addr_i       (req_addr_i),
    .ac_valid_o       (ac_valid_o),
    .ac_ready_i       (ac_ready_i),
    .ac_addr_o        (ac_addr_o),
    .ac_snoop_o       (ac_snoop_o),
    .cr_valid_i       (cr_valid_i),
    .cr_ready_o       (cr_ready_o),
    .cr_resp_i        (cr_resp_i),
    .cd_busy_i        (cd_busy_i),
    .mu_valid_o       (mu_valid_o),
    .mu_ready_i       (mu_ready_i),
    .mu_op_o          (mu_op_o),
    .data_available_o (data_available_o),
    .first_responder_o(first_responder_o),
    .done_valid_o     (done_valid_o),
    .done_ready_i     (done_ready_i),
    .shared_o         (shared_o),
    .dirty_o          (dirty_o)
  );

  typedef struct {
    bit         is_done;
    logic [1:0] op;
    logic [3:0] da;
    logic [1:0] first;
    bit         has_first;
    bit         shared;
    bit         dirty;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_addr = 64'd0;
  int          exp_src = 0;
  bit          exp_write = 1'b0;
  logic [4:0]  resp [4];
  int          csched [4];
  int          asched [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input bit is_done, input logic [1:0] op, input logic [3:0] da,
                          input logic [1:0] first, input bit has_first, input bit shared, input bit dirty);
    exp_t e;
    e.is_done = is_done; e.op = op; e.da = da; e.first = first;
    e.has_first = has_first; e.shared = shared; e.dirty = dirty;
    expq.push_back(e);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_req_ready"}, req_ready_o, 0);
    chk({tag, "_ac_valid"}, ac_valid_o, 0);
    chk({tag, "_cr_ready"}, cr_ready_o, 0);
    chk({tag, "_mu_valid"}, mu_valid_o, 0);
    chk({tag, "_done_valid"}, done_valid_o, 0);
    chk({tag, "_mu_op"}, mu_op_o, SEND_AXI_REQ_R);
    chk({tag, "_data_avail"}, data_available_o, 0);
    chk({tag, "_first"}, first_responder_o, 0);
    chk({tag, "_shared_dirty"}, {shared_o, dirty_o}, 0);
  endtask

  // Monitor: protocol checks on snoops, scoreboard pops on MU and completion handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      if (ac_valid_o != 4'b0000) begin
        chk("ac_src_masked", ac_valid_o[exp_src], 0);
        chk("ac_addr", ac_addr_o, {exp_addr[63:4], 4'b0000});
        chk("ac_snoop", ac_snoop_o, exp_write ? 64'h9 : 64'h1);
      end
      if (mu_valid_o && mu_ready_i) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL mu_unexpected: got op %0d, expected no MU op at %0t", mu_op_o, $time);
        end else begin
          e = expq.pop_front();
          chk("mu_kind", e.is_done, 0);
          chk("mu_op", mu_op_o, e.op);
          chk("mu_data_avail", data_available_o, e.da);
          if (e.has_first) chk("mu_first", first_responder_o, e.first);
        end
      end
      if (done_valid_o && done_ready_i) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: got done_valid 1, expected 0 at %0t", $time);
        end else begin
          e = expq.pop_front();
          chk("done_kind", e.is_done, 1);
          chk("done_data_avail", data_available_o, e.da);
          chk("done_shared", shared_o, e.shared);
          chk("done_dirty", dirty_o, e.dirty);
          if (e.has_first) chk("done_first", first_responder_o, e.first);
        end
      end
    end
  end

  task automatic run_txn(input bit w, input int src, input logic [63:0] addr,
                         input bit busy_test, input int abort_cr);
    logic [3:0] tgt, da, crd, acd;
    bit dirty, shared, acc, got_done, aborted;
    int first, best, ncr, busy_left, mu_cnt;
    tgt = 4'b1111;
    tgt[src] = 1'b0;
    da = 4'd0; dirty = 0; shared = 0; first = -1; best = 1 << 20;
    // Reference model: merge responses of the snooped ports, earliest data response wins.
    for (int i = 0; i < 4; i++) begin
      if (i != src) begin
        if (resp[i][0] && !resp[i][1]) begin
          da[i] = 1'b1;
          if (resp[i][2]) dirty = 1;
          if (csched[i] < best) begin best = csched[i]; first = i; end
        end
        if (resp[i][3]) shared = 1;
      end
    end
    if (abort_cr < 0) begin
      if (!w && dirty) push_exp(0, WRITE_BACK_R, da, 2'(first), first >= 0, shared, dirty);
      if (!w && da == 4'd0) push_exp(0, SEND_AXI_REQ_R, da, 2'(first), first >= 0, shared, dirty);
      if (w && dirty) push_exp(0, WRITE_BACK_W, da, 2'(first), first >= 0, shared, dirty);
      if (w) push_exp(0, SEND_AXI_REQ_W, da, 2'(first), first >= 0, shared, dirty);
      push_exp(1, 2'd0, da, 2'(first), first >= 0, shared, dirty);
    end
    exp_src = src; exp_addr = addr; exp_write = w;
    for (int i = 0; i < 4; i++) cr_resp_i[i] = resp[i];

    req_valid_i = 1; req_is_write_i = w; req_src_i = 2'(src); req_addr_i = addr; cd_busy_i = 1;
    @(negedge clk);
    chk("req_ready_busy", req_ready_o, 0);
    @(posedge clk); #1;
    cd_busy_i = 0;
    acc = 0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready_o;
      @(posedge clk); #1;
    end
    req_valid_i = 0;
    chk("req_accept", acc, 1);

    crd = 4'd0; acd = 4'd0; ncr = 0; aborted = 0;
    for (int k = 0; k < 40 && !((crd == tgt) && (acd == tgt)) && !aborted; k++) begin
      for (int i = 0; i < 4; i++) begin
        cr_valid_i[i] = tgt[i] && !crd[i] && (csched[i] <= k);
        ac_ready_i[i] = tgt[i] && !acd[i] && (asched[i] <= k);
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (cr_valid_i[i] && cr_ready_o[i]) begin
          crd[i] = 1'b1;
          ncr++;
          chk("cr_cycle", k, csched[i]);
        end
        if (ac_valid_o[i] && ac_ready_i[i]) acd[i] = 1'b1;
      end
      @(posedge clk); #1;
      if (abort_cr >= 0 && ncr >= abort_cr) begin
        cr_valid_i = 4'd0; ac_ready_i = 4'd0; rst_i = 1;
        @(negedge clk);
        check_quiet("abort_rst");
        @(posedge clk); #1;
        rst_i = 0;
        aborted = 1;
      end
    end
    cr_valid_i = 4'd0; ac_ready_i = 4'd0;
    if (aborted) return;
    chk("cr_ports", crd, tgt);
    chk("ac_ports", acd, tgt);

    busy_left = 0; mu_cnt = 0; got_done = 0;
    for (int k = 0; k < 60 && !got_done; k++) begin
      mu_ready_i = ($urandom_range(0, 3) != 0);
      done_ready_i = ($urandom_range(0, 1) == 1);
      cd_busy_i = (busy_left > 0);
      @(negedge clk);
      if (cd_busy_i) begin
        chk("mu_busy_gate", mu_valid_o, 0);
        busy_left--;
      end
      if (mu_valid_o && mu_ready_i) begin
        mu_cnt++;
        if (busy_test && mu_cnt == 1) busy_left = 3;
      end
      if (done_valid_o && done_ready_i) got_done = 1;
      @(posedge clk); #1;
    end
    mu_ready_i = 0; done_ready_i = 0; cd_busy_i = 0;
    chk("done_seen", got_done, 1);
    chk("exp_drained", expq.size(), 0);
  endtask

  task automatic set_port(input int p, input logic [4:0] r, input int cs, input int as_);
    resp[p] = r; csched[p] = cs; asched[p] = as_;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) set_port(i, 5'b00000, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst_i = 0;
    @(posedge clk); #1;

    // Read, no data anywhere: fetch from memory.
    set_port(0, 5'b00000, 0, 0); set_port(1, 5'b00000, 0, 2);
    set_port(2, 5'b00000, 1, 0); set_port(3, 5'b00000, 2, 1);
    run_txn(0, 0, 64'h1234_5678_9ABC_DEF7, 0, -1);

    // Read, dirty data on 3 then clean data on 2 a cycle later.
    set_port(0, 5'b00000, 0, 0); set_port(1, 5'b00000, 0, 0);
    set_port(2, 5'b00001, 1, 0); set_port(3, 5'b00101, 0, 3);
    run_txn(0, 1, 64'h0000_0000_0000_1F3C, 0, -1);

    // Write, dirty data from port 0: write back then forward, second op held by cd_busy.
    set_port(0, 5'b00101, 1, 0); set_port(1, 5'b00000, 0, 1);
    set_port(2, 5'b00000, 0, 0); set_port(3, 5'b10000, 2, 2);
    run_txn(1, 2, 64'hFFFF_0000_AAAA_5555, 1, -1);

    // Read, clean data on 0 and 3 in the same cycle: lowest index wins, no MU op.
    set_port(0, 5'b00001, 2, 0); set_port(1, 5'b00000, 0, 0);
    set_port(2, 5'b00000, 0, 1); set_port(3, 5'b01001, 2, 0);
    run_txn(0, 1, 64'h0000_00AB_CDEF_0008, 0, -1);

    // Data with error is not usable data.
    set_port(0, 5'b00000, 0, 0); set_port(1, 5'b00000, 1, 0);
    set_port(2, 5'b00011, 0, 0); set_port(3, 5'b01000, 1, 1);
    run_txn(0, 0, 64'h0000_0000_0000_004F, 0, -1);

    // Reset in SNOOP after two of three responses, then a fresh request.
    set_port(0, 5'b00000, 0, 0); set_port(1, 5'b00101, 0, 0);
    set_port(2, 5'b00001, 1, 0); set_port(3, 5'b00001, 99, 0);
    run_txn(0, 0, 64'hDEAD_BEEF_0000_1234, 0, 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_quiet", {mu_valid_o, done_valid_o, ac_valid_o, cr_ready_o}, 0);
      @(posedge clk); #1;
    end
    set_port(0, 5'b00000, 0, 0); set_port(1, 5'b01101, 1, 0);
    set_port(2, 5'b00001, 0, 1); set_port(3, 5'b00000, 0, 0);
    run_txn(1, 0, 64'h0000_1111_2222_3339, 1, -1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++)
        set_port(i, 5'($urandom_range(0, 31)), int'($urandom_range(0, 5)), int'($urandom_range(0, 6)));
      run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), {$urandom, $urandom},
              1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccu_snoop_resp_collector.md
CCU_SNOOP_RESP_COLLECTOR -- requirements
Module: ccu_snoop_resp_collector

Interface
REQ-001 Param NoMstPorts, default 4, number of cache masters; SHALL be >= 2.
REQ-002 Param AddrWidth, default 64, address width.
REQ-003 Localparam MstIdxBits = $clog2(NoMstPorts).
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 req_valid_i / req_ready_o  in/out  1  coherent request handshake.
REQ-007 req_is_write_i  in  1  1 = AW-origin request, 0 = AR-origin.
REQ-008 req_src_i  in  MstIdxBits  initiating master; never snooped.
REQ-009 req_addr_i  in  AddrWidth  request address.
REQ-010 ac_valid_o / ac_ready_i  out/in  NoMstPorts  per-port snoop address handshake.
REQ-011 ac_addr_o  out  AddrWidth  snoop address; ac_snoop_o  out  4  snoop type.
REQ-012 cr_valid_i / cr_ready_o  in/out  NoMstPorts  per-port snoop response handshake.
REQ-013 cr_resp_i  in  NoMstPorts x 5  CRRESP: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
REQ-014 cd_busy_i  in  1  memory unit still draining snoop data.
REQ-015 mu_valid_o / mu_ready_i  out/in  1  memory-unit op handshake.
REQ-016 mu_op_o  out  mu_op_e (ccu_ctrl_pkg)  memory-unit op.
REQ-017 data_available_o  out  NoMstPorts; first_responder_o  out  MstIdxBits.
REQ-018 done_valid_o / done_ready_i  out/in  1  completion to response path; shared_o, dirty_o  out  1.

Function
REQ-019 FSM states: IDLE, SNOOP, MU_REQ, MU_REQ2, DONE.
REQ-020 IDLE: req_ready_o = !cd_busy_i; on req_valid_i && req_ready_o latch is_write, src, addr, clear masks -> SNOOP.
REQ-021 Target mask = all ports except latched src.
REQ-022 ac_addr_o = latched addr with bits [3:0] forced 0; ac_snoop_o = 4'b0001 (ReadShared) for reads, 4'b1001 (CleanInvalid) for writes.
REQ-023 SNOOP: ac_valid_o[i] = target[i] && !ac_done[i]; ac_done[i] sets on ac_valid_o[i] && ac_ready_i[i]; ports handshake independently, no ordering.
REQ-024 SNOOP: cr_ready_o[i] = target[i] && !cr_done[i]; accepting CR before own AC handshake is legal.
REQ-025 On CR handshake of port i: data_avail[i] = DataTransfer && !Error; dirty |= PassDirty && data_avail[i]; shared |= IsShared.
REQ-026 first_responder = port of earliest-cycle CR handshake with data_avail set; same-cycle ties -> lowest index; later data responses never overwrite it.
REQ-027 Leave SNOOP the cycle after ac_done and cr_done both equal target mask; no partial exit.
REQ-028 Op select: read & dirty -> WRITE_BACK_R to MU_REQ; read & !dirty -> DONE (no MU op); write & dirty -> WRITE_BACK_W to MU_REQ then SEND_AXI_REQ_W in MU_REQ2; write & !dirty -> SEND_AXI_REQ_W in MU_REQ.
REQ-029 Read with no data_avail SHALL select SEND_AXI_REQ_R in MU_REQ.
REQ-030 MU_REQ/MU_REQ2: mu_valid_o = 1, mu_op_o/data_available_o/first_responder_o stable until mu_ready_i; then advance (MU_REQ -> MU_REQ2 only for write-dirty, else DONE).
REQ-031 MU_REQ2 SHALL not assert mu_valid_o while cd_busy_i = 1.
REQ-032 DONE: done_valid_o = 1 with shared_o, dirty_o, data_available_o, first_responder_o stable; done_ready_i -> IDLE.
REQ-033 No new request accepted outside IDLE; req_ready_o = 0 there.
REQ-034 data_available_o/first_responder_o hold last values outside MU_REQ/DONE.

Reset
REQ-035 rst_i asserted, any state: FSM -> IDLE, masks, flags, first_responder, latched request cleared to 0 immediately.
REQ-036 During reset: req_ready_o, ac_valid_o, cr_ready_o, mu_valid_o, done_valid_o = 0; mu_op_o = SEND_AXI_REQ_R.
REQ-037 Reset mid-SNOOP/MU_REQ drops the transaction; no output pulse follows deassertion.

Verification
REQ-038 Read, src=0, ports 1-3 reply CR=5'b00000 -> AC on 1,2,3 with addr[3:0]=0, snoop=0001; mu_op=SEND_AXI_REQ_R, data_available=4'b0000, then done_valid.
REQ-039 Read, src=1, port 3 CR=5'b00101 at cycle t, port 2 CR=5'b00001 at t+1 -> first_responder=3, data_available=4'b1100, mu_op=WRITE_BACK_R.
REQ-040 Write, src=2, port 0 CR=5'b00101 -> MU ops in order WRITE_BACK_W then SEND_AXI_REQ_W; second held off while cd_busy_i=1.
REQ-041 Read, ports 0 and 3 data in same cycle, clean, src=1 -> first_responder=0, no mu_valid_o, done_valid with shared per IsShared.
REQ-042 CR=5'b00011 (data+error) on port 2 -> data_available[2]=0; cd_busy_i=1 in IDLE -> req_ready_o=0.
REQ-043 rst_i pulsed while in SNOOP with 2 of 3 CRs received -> all outputs 0 next edge; fresh request afterwards completes normally.
